// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM port master: funct3 codes, FSM encoding
// and byte-lane helpers used by both the control and datapath.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RMW_WRITE,
        ST_RESP
    } state_t;

    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        unique case (size)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_repl(
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        unique case (size)
            2'b00:   store_repl = {4{wdata[7:0]}};
            2'b01:   store_repl = {2{wdata[15:0]}};
            default: store_repl = wdata;
        endcase
    endfunction

    // Illegal code for the direction, or an access that straddles its natural alignment.
    function automatic logic req_error(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic legal;
        logic mis;
        unique case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !we;
            default:          legal = 1'b0;
        endcase
        mis = ((funct3[1:0] == 2'b01) && off[0]) ||
              ((funct3[1:0] == 2'b10) && (off != 2'b00));
        req_error = !legal || mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge of
// store data into a fetched word for read-modify-write stores.
module lsu_load_align (
    input  logic [31:0] rdata_word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    import mem_pkg::*;

    logic [31:0] shifted;
    logic [31:0] bm;
    logic [3:0]  mask;

    assign shifted = rdata_word >> {off, 3'b000};
    assign mask    = lane_mask(funct3[1:0], off);

    always_comb begin
        load_data = rdata_word;
        unique case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            F3_W:    load_data = rdata_word;
            default: load_data = rdata_word;
        endcase
    end

    always_comb begin
        bm = '0;
        for (int i = 0; i < 4; i++) begin
            bm[8*i +: 8] = {8{mask[i]}};
        end
    end

    assign merge_data = (rdata_word & ~bm) |
                        (store_repl(funct3[1:0], wdata) & bm);

endmodule

// File: rtl/sram_port_master.sv
// Requester for one synchronous SRAM port: accepts byte-addressed loads and
// stores, drives the port, and returns one aligned response per request.
module sram_port_master #(
    parameter int ADDR_W = 12,
    parameter bit RMW    = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [ADDR_W+1:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              CSN,
    output logic [ADDR_W-1:0] ADDR,
    output logic              WE,
    output logic [3:0]        BE,
    output logic [31:0]       DI,
    input  logic [31:0]       DO
);
    import mem_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       merged_q;
    logic              err_q;

    logic        accept;
    logic        req_err;
    logic        rmw_op;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = REQ_VALID && (state_q == ST_IDLE);
    assign req_err = req_error(REQ_WE, REQ_FUNCT3, REQ_ADDR[1:0]);
    assign rmw_op  = RMW && we_q && (f3_q[1:0] != 2'b10);

    lsu_load_align u_align (
        .rdata_word (DO),
        .off        (off_q),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = req_err ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = (we_q && !rmw_op) ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE:   state_d = we_q ? ST_RMW_WRITE : ST_RESP;
            ST_RMW_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (RSP_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            off_q    <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= REQ_ADDR[ADDR_W+1:2];
                off_q   <= REQ_ADDR[1:0];
                f3_q    <= REQ_FUNCT3;
                we_q    <= REQ_WE;
                wdata_q <= REQ_WDATA;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            // DO is valid here, one cycle after the read edge
            if (state_q == ST_CAPTURE) begin
                if (we_q) merged_q <= merge_data;
                else      rdata_q  <= load_data;
            end
            if ((state_q == ST_RESP) && RSP_READY) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        RSP_RDATA = '0;
        RSP_ERR   = 1'b0;
        CSN       = 1'b1;
        ADDR      = '0;
        WE        = 1'b0;
        BE        = '0;
        DI        = '0;
        unique case (state_q)
            ST_IDLE: REQ_READY = 1'b1;
            ST_ISSUE: begin
                CSN  = 1'b0;
                ADDR = addr_q;
                if (we_q && !rmw_op) begin
                    WE = 1'b1;
                    BE = lane_mask(f3_q[1:0], off_q);
                    DI = store_repl(f3_q[1:0], wdata_q);
                end else begin
                    BE = 4'hF;
                end
            end
            ST_RMW_WRITE: begin
                CSN  = 1'b0;
                ADDR = addr_q;
                WE   = 1'b1;
                BE   = 4'hF;
                DI   = merged_q;
            end
            ST_RESP: begin
                RSP_VALID = 1'b1;
                RSP_RDATA = rdata_q;
                RSP_ERR   = err_q;
            end
            default: ;
        endcase
    end

endmodule
